// File: rtl/mfp_adc_max10_sched_pkg.sv
// Shared types and constants for the MAX10 ADC conversion scheduler.
package mfp_adc_max10_pkg;

  localparam int ADC_DATA_W = 12;
  localparam int ADC_CHAN_W = 5;

  // MAX10 ADC special channels: on-die temperature sensor and "no channel".
  localparam logic [ADC_CHAN_W-1:0] CH_T    = 5'd17;
  localparam logic [ADC_CHAN_W-1:0] CH_NONE = 5'd18;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_CMD  = 1'b1
  } sched_state_e;

endpackage

// File: rtl/mfp_adc_max10_sched_if.sv
// MAX10 ADC IP command/response stream; master = scheduler, slave = ADC IP.
interface mfp_adc_max10_sched_if;
  import mfp_adc_max10_pkg::*;

  logic                  ADC_C_Valid;
  logic [ADC_CHAN_W-1:0] ADC_C_Channel;
  logic                  ADC_C_SOP;
  logic                  ADC_C_EOP;
  logic                  ADC_C_Ready;
  logic                  ADC_R_Valid;
  logic [ADC_CHAN_W-1:0] ADC_R_Channel;
  logic [ADC_DATA_W-1:0] ADC_R_Data;

  modport master (
    output ADC_C_Valid, ADC_C_Channel, ADC_C_SOP, ADC_C_EOP,
    input  ADC_C_Ready, ADC_R_Valid, ADC_R_Channel, ADC_R_Data
  );

  modport slave (
    input  ADC_C_Valid, ADC_C_Channel, ADC_C_SOP, ADC_C_EOP,
    output ADC_C_Ready, ADC_R_Valid, ADC_R_Channel, ADC_R_Data
  );

endinterface

// File: rtl/mfp_adc_max10_sched_fifo.sv
// In-order tag FIFO: remembers which requester owns each outstanding conversion.
module mfp_adc_tag_fifo #(
  parameter int W     = 2,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_push,
  input  logic [W-1:0]             i_data,
  input  logic                     i_pop,
  output logic [W-1:0]             o_data,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          w_do_push;
  logic          w_do_pop;

  assign o_full    = (r_count == (AW+1)'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_data    = r_mem[r_rd_ptr];
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);

  // NOTE: storage is deliberately not reset; only pointers and count define validity.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_data;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/mfp_adc_max10_sched.sv
// Round-robin scheduler of single-sample requests onto the MAX10 ADC stream.
// Optional head-of-line timeout is enabled by defining ADC_SCHED_TIMEOUT_EN.
module mfp_adc_max10_sched
  import mfp_adc_max10_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int TAG_W   = 2,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 1024
) (
  input  logic                       CLK,
  input  logic                       RESETn,
  input  logic [NREQ-1:0]            req_valid,
  input  logic [NREQ*ADC_CHAN_W-1:0] req_channel,
  output logic [NREQ-1:0]            req_ready,
  output logic [NREQ-1:0]            rsp_valid,
  output logic [ADC_DATA_W-1:0]      rsp_data,
  output logic [ADC_CHAN_W-1:0]      rsp_channel,
  output logic                       rsp_timeout,
  mfp_adc_max10_sched_if.master      adc,
  output logic                       busy,
  output logic                       err_spurious,
  input  logic                       err_clear
);

  sched_state_e          r_state;
  sched_state_e          w_state_nxt;
  logic                  r_cmd_valid;
  logic [TAG_W-1:0]      r_id;
  logic [ADC_CHAN_W-1:0] r_chan;
  logic [TAG_W-1:0]      r_rr_ptr;
  logic                  w_grant;
  logic                  w_accept;
  logic [TAG_W-1:0]      w_win;

  logic [TAG_W-1:0]      w_head;
  logic                  w_full;
  logic                  w_empty;
  logic [$clog2(DEPTH):0] w_count;
  logic                  w_pop_real;
  logic                  w_expire;
  logic                  w_pop;
  logic                  w_spurious;

  logic [NREQ-1:0]       r_rsp_valid;
  logic [ADC_DATA_W-1:0] r_rsp_data;
  logic [ADC_CHAN_W-1:0] r_rsp_channel;
  logic                  r_rsp_timeout;
  logic                  r_err_spurious;

  // First set bit at or after ptr, wrapping modulo NREQ.
  function automatic logic [TAG_W-1:0] rr_pick(input logic [NREQ-1:0] req,
                                              input logic [TAG_W-1:0] ptr);
    logic [TAG_W-1:0] pick;
    logic             found;
    int               idx;
    pick  = ptr;
    found = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      idx = (int'(ptr) + i) % NREQ;
      if (!found && req[idx]) begin
        pick  = TAG_W'(idx);
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  assign w_win = rr_pick(req_valid, r_rr_ptr);

  // NOTE: every always_comb output gets a default first so no latch can be inferred.
  always_comb begin
    w_state_nxt = r_state;
    w_grant     = 1'b0;
    w_accept    = 1'b0;
    case (r_state)
      S_IDLE: if (|req_valid && !w_full) begin
        w_grant     = 1'b1;
        w_state_nxt = S_CMD;
      end
      S_CMD: if (adc.ADC_C_Ready) begin
        w_accept    = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      r_state     <= S_IDLE;
      r_cmd_valid <= 1'b0;
      r_id        <= '0;
      r_chan      <= '0;
      r_rr_ptr    <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_cmd_valid <= (w_state_nxt == S_CMD);
      if (w_grant) begin
        r_id   <= w_win;
        r_chan <= req_channel[ADC_CHAN_W*w_win +: ADC_CHAN_W];
      end
      if (w_accept)
        r_rr_ptr <= (r_id == TAG_W'(NREQ-1)) ? '0 : r_id + 1'b1;
    end
  end

  assign req_ready         = w_accept ? (NREQ'(1) << r_id) : '0;
  assign adc.ADC_C_Valid   = r_cmd_valid;
  assign adc.ADC_C_SOP     = r_cmd_valid;
  assign adc.ADC_C_EOP     = r_cmd_valid;
  assign adc.ADC_C_Channel = r_cmd_valid ? r_chan : '0;

  mfp_adc_tag_fifo #(
    .W     (TAG_W),
    .DEPTH (DEPTH)
  ) u_tag_fifo (
    .clk     (CLK),
    .rst_n   (RESETn),
    .i_push  (w_accept),
    .i_data  (r_id),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  assign w_pop_real = adc.ADC_R_Valid && !w_empty;
  assign w_spurious = adc.ADC_R_Valid && w_empty;
  assign w_pop      = w_pop_real || w_expire;

`ifdef ADC_SCHED_TIMEOUT_EN
  localparam int TO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  logic [TO_W-1:0] r_to_cnt;

  // A real response arriving on the expiry cycle takes precedence.
  assign w_expire = !w_empty && !adc.ADC_R_Valid && (r_to_cnt == TO_W'(TIMEOUT-1));

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn)               r_to_cnt <= '0;
    else if (w_empty || w_pop) r_to_cnt <= '0;
    else                       r_to_cnt <= r_to_cnt + 1'b1;
  end
`else
  assign w_expire = 1'b0;
`endif

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      r_rsp_valid    <= '0;
      r_rsp_data     <= '0;
      r_rsp_channel  <= '0;
      r_rsp_timeout  <= 1'b0;
      r_err_spurious <= 1'b0;
    end else begin
      r_rsp_valid   <= '0;
      r_rsp_timeout <= 1'b0;
      if (w_pop_real) begin
        r_rsp_valid   <= NREQ'(1) << w_head;
        r_rsp_data    <= adc.ADC_R_Data;
        r_rsp_channel <= adc.ADC_R_Channel;
      end else if (w_expire) begin
        r_rsp_valid   <= NREQ'(1) << w_head;
        r_rsp_data    <= '0;
        r_rsp_channel <= '0;
        r_rsp_timeout <= 1'b1;
      end
      if (w_spurious)     r_err_spurious <= 1'b1;
      else if (err_clear) r_err_spurious <= 1'b0;
    end
  end

  assign rsp_valid    = r_rsp_valid;
  assign rsp_data     = r_rsp_data;
  assign rsp_channel  = r_rsp_channel;
  assign rsp_timeout  = r_rsp_timeout;
  assign err_spurious = r_err_spurious;
  assign busy         = (r_state == S_CMD) || (w_count != '0);

endmodule
